// File: rtl/pattern_pkg.sv
// pattern_pkg: shared FSM state type and parameter limits for pattern_counter
package pattern_pkg;
    typedef enum logic [1:0] {UNCFG, FILL, ARMED} state_t;
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 2;
    localparam int CNT_W_MAX = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with sticky overflow and synchronous clear
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         ovf
);
    logic [W-1:0] r_count;
    logic         r_ovf;
    // clear wins over increment; an increment at full scale only flags overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (inc) begin
            if (&r_count) r_ovf <= 1'b1;
            else r_count <= r_count + 1'b1;
        end
    end
    assign count = r_count;
    assign ovf   = r_ovf;
endmodule

// File: rtl/pattern_counter.sv
// pattern_counter: serial bit-pattern matcher with configurable length, overlap mode and saturating match count
module pattern_counter
    import pattern_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       x,
    input  logic                       x_valid,
    input  logic                       cfg_load,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       clr,
    output logic [CNT_W-1:0]           count,
    output logic                       hit,
    output logic                       overflow,
    output logic                       cfg_err
);
    localparam int LW = $clog2(PAT_W+1);

    state_t           r_state;
    logic [PAT_W-1:0] r_hist;
    logic [LW-1:0]    r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LW-1:0]    r_len;
    logic             r_ovl;
    logic             r_hit;
    logic             r_cfg_err;

    logic             w_cfg_ok;
    logic             w_acc_load;
    logic             w_bit;
    logic [PAT_W-1:0] w_hist_n;
    logic [LW-1:0]    w_fill_n;
    logic [PAT_W-1:0] w_mask;
    logic             w_match;

    assign w_cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(PAT_W));
    assign w_acc_load = cfg_load && w_cfg_ok;
    // an accepted load swallows any same-cycle bit
    assign w_bit      = x_valid && !w_acc_load && (r_state != UNCFG);
    assign w_hist_n   = (r_hist << 1) | {{(PAT_W-1){1'b0}}, x};
    assign w_fill_n   = (r_fill == LW'(PAT_W)) ? r_fill : r_fill + 1'b1;
    assign w_match    = w_bit && (w_fill_n >= r_len) && (((w_hist_n ^ r_pat) & w_mask) == '0);

    // low r_len bits of the history take part in the comparison
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) w_mask[i] = (i < int'(r_len));
    end

    // configuration, history, fill tracking and state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= UNCFG;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= '0;
            r_len     <= '0;
            r_ovl     <= 1'b0;
            r_hit     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_hit     <= w_match;
            r_cfg_err <= cfg_load && !w_cfg_ok;
            if (w_acc_load) begin
                r_state <= FILL;
                r_pat   <= cfg_pattern;
                r_len   <= cfg_len;
                r_ovl   <= cfg_overlap;
                r_hist  <= '0;
                r_fill  <= '0;
            end else if (w_bit) begin
                r_hist <= w_hist_n;
                if (w_match && !r_ovl) begin
                    r_fill  <= '0;
                    r_state <= FILL;
                end else begin
                    r_fill  <= w_fill_n;
                    r_state <= (w_fill_n >= r_len) ? ARMED : FILL;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_match),
        .clr  (clr),
        .count(count),
        .ovf  (overflow)
    );

    assign hit     = r_hit;
    assign cfg_err = r_cfg_err;
endmodule
